key_entry_scan: RTL and testbench

KEY_ENTRY_SCAN -- requirements
Module: key_entry_scan

---
 rtl/key_entry_scan_pkg.sv | 19 +
 rtl/key_entry_scan_seg7_decode.sv | 24 ++
 rtl/key_entry_scan.sv | 89 ++++++++
 tb/tb_key_entry_scan.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/key_entry_scan_pkg.sv
// key_entry_scan_pkg: key codes, key FSM states and 7-segment constants shared by the keypad entry slice
package key_entry_scan_pkg;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_CLR = 4'hD;
  localparam logic [3:0] KEY_BKSP = 4'hE;
  localparam logic [3:0] KEY_ENT = 4'hF;
  typedef enum logic {WAIT_PRESS = 1'b0, WAIT_RELEASE = 1'b1} key_state_t;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] BLANK = 8'hFF;
endpackage

// File: rtl/key_entry_scan_seg7_decode.sv
// seg7_decode: BCD nibble to active-low {dp,g,f,e,d,c,b,a}, non-decimal nibbles blank
module seg7_decode
  import key_entry_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);
  // pure lookup; dp stays off in every code
  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = BLANK;
    endcase
  end
endmodule

// File: rtl/key_entry_scan.sv
// key_entry_scan: keypad digit entry buffer with 8-digit multiplexed display; KEY_ENTRY_SCAN_BLANK_EN blanks unused leading digits
module key_entry_scan
  import key_entry_scan_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_flag,
  input  logic [3:0]  key_code,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out,
  output logic [31:0] entry_value,
  output logic        entry_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  key_state_t state;
  logic [31:0] buffer;
  logic [3:0] digit_cnt;
  logic [CW-1:0] scan_cnt;
  logic [2:0] idx;
  logic [2:0] next_idx;
  logic [3:0] next_digit;
  logic [7:0] dec_seg;
  logic [7:0] next_seg;
  logic wrap;
  assign wrap = scan_cnt == SCAN_LAST;
  assign next_idx = idx + 3'd1;
  assign next_digit = buffer[{next_idx, 2'b00} +: 4];
  seg7_decode u_dec (.digit(next_digit), .seg(dec_seg));
`ifdef KEY_ENTRY_SCAN_BLANK_EN
  assign next_seg = ({1'b0, next_idx} >= digit_cnt && !(next_idx == 3'd0 && digit_cnt == 4'd0)) ? BLANK : dec_seg;
`else
  assign next_seg = dec_seg;
`endif
  // slot timer; the display latches the pre-command buffer digit at each slot change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx <= 3'd0;
      seg_an <= 8'hFE;
      seg_out <= SEG_0;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
      if (wrap) begin
        idx <= next_idx;
        seg_an <= ~(8'd1 << next_idx);
        seg_out <= next_seg;
      end
    end
  end
  // one command per press, executed on the press edge; holding the key never repeats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_PRESS;
      buffer <= '0;
      digit_cnt <= 4'd0;
      entry_value <= '0;
      entry_done <= 1'b0;
    end else begin
      entry_done <= 1'b0;
      if (state == WAIT_RELEASE) begin
        if (!key_flag) state <= WAIT_PRESS;
      end else if (key_flag) begin
        state <= WAIT_RELEASE;
        if (key_code <= KEY_MAX_DIGIT) begin
          if (digit_cnt < 4'd8) begin
            buffer <= {buffer[27:0], key_code};
            digit_cnt <= digit_cnt + 4'd1;
          end
        end else if (key_code == KEY_BKSP) begin
          if (digit_cnt != 4'd0) begin
            buffer <= {4'h0, buffer[31:4]};
            digit_cnt <= digit_cnt - 4'd1;
          end
        end else if (key_code == KEY_CLR) begin
          buffer <= '0;
          digit_cnt <= 4'd0;
        end else if (key_code == KEY_ENT) begin
          entry_value <= buffer;
          entry_done <= 1'b1;
          buffer <= '0;
          digit_cnt <= 4'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_key_entry_scan.sv
// tb_key_entry_scan: randomized keypad presses checked every cycle against a digit-queue model of entry and display
module tb_key_entry_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_flag = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [7:0] seg_an;
  logic [7:0] seg_out;
  logic [31:0] entry_value;
  logic entry_done;
  int checks = 0;
  int errors = 0;
  int q[$];
  bit held;
  int t;
  logic [7:0] m_an;
  logic [7:0] m_seg;
  logic [31:0] m_val;
  logic m_done;
  bit [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                         8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  key_entry_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .key_code(key_code),
    .seg_an(seg_an), .seg_out(seg_out), .entry_value(entry_value), .entry_done(entry_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic int digit_at(input int i);
    return i < q.size() ? q[q.size() - 1 - i] : 0;
  endfunction

  function automatic logic [7:0] show(input int i);
`ifdef KEY_ENTRY_SCAN_BLANK_EN
    if (i >= q.size() && !(i == 0 && q.size() == 0)) return 8'hFF;
`endif
    return lut[digit_at(i)];
  endfunction

  task automatic model_reset();
    q.delete();
    held = 1'b0;
    t = 0;
    m_an = 8'hFE;
    m_seg = 8'hC0;
    m_val = '0;
    m_done = 1'b0;
  endtask

  task automatic model_step();
    int k;
    k = int'(key_code);
    if (t % 4 == 3) begin
      int n;
      n = (t / 4 + 1) % 8;
      m_an = ~(8'd1 << n);
      m_seg = show(n);
    end
    t++;
    m_done = 1'b0;
    if (!held && key_flag) begin
      held = 1'b1;
      if (k <= 9) begin
        if (q.size() < 8) q.push_back(k);
      end else if (k == 14) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (k == 13) begin
        q.delete();
      end else if (k == 15) begin
        m_val = '0;
        foreach (q[i]) m_val = (m_val << 4) | 32'(q[i]);
        m_done = 1'b1;
        q.delete();
      end
    end else if (held && !key_flag) begin
      held = 1'b0;
    end
  endtask

  task automatic check_all();
    check("seg_an", 32'(seg_an), 32'(m_an));
    check("seg_out", 32'(seg_out), 32'(m_seg));
    check("entry_done", 32'(entry_done), 32'(m_done));
    check("entry_value", entry_value, m_val);
  endtask

  task automatic tick(input bit kf, input logic [3:0] kc);
    key_flag = kf;
    key_code = kc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic press(input logic [3:0] kc, input int hold, input int rel);
    repeat (hold) tick(1'b1, kc);
    repeat (rel) tick(1'b0, 4'($urandom));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    model_reset();
    check_all();
    rst = 1'b0;
    repeat (40) tick(1'b0, 4'h0);
    press(4'h1, 5, 5);
    press(4'h2, 5, 5);
    press(4'h3, 5, 5);
    press(4'hF, 5, 5);
    check("enter_123", entry_value, 32'h00000123);
    for (int d = 1; d <= 9; d++) press(4'(d), 2, 2);
    press(4'hF, 2, 2);
    check("enter_9_digits", entry_value, 32'h12345678);
    press(4'h4, 3, 3);
    press(4'h5, 3, 3);
    press(4'hE, 3, 3);
    press(4'hF, 3, 3);
    check("backspace", entry_value, 32'h00000004);
    press(4'hE, 3, 3);
    check("backspace_empty", entry_value, 32'h00000004);
    press(4'h7, 50, 5);
    press(4'hD, 3, 3);
    repeat (40) tick(1'b0, 4'h0);
    press(4'h2, 3, 3);
    repeat (40) tick(1'b0, 4'h0);
    press(4'hF, 2, 2);
    check("enter_2", entry_value, 32'h00000002);
    press(4'h1, 2, 2);
    press(4'h2, 2, 2);
    press(4'h3, 2, 2);
    repeat (3) tick(1'b1, 4'h5);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    repeat (3) tick(1'b1, 4'h5);
    repeat (3) tick(1'b0, 4'h0);
    press(4'hF, 2, 2);
    check("reset_press", entry_value, 32'h00000005);
    repeat (300) begin
      logic [3:0] kc;
      kc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      press(kc, $urandom_range(1, 6), $urandom_range(1, 4));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
